// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer: FSM states,
// CSR addresses and mstatus field positions.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STAT_T,
    W_STAT_R,
    RD_TGT,
    REDIRECT
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int unsigned ECALL_M = 11;

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle of request, CSR-port and redirect signals around the trap sequencer.
// The sequencer uses the slave view; the core/CSR side uses the master view.
interface trap_sequencer_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  logic              trap_req;
  logic [XLEN-1:0]   trap_cause;
  logic [XLEN-1:0]   trap_pc;
  logic              mret_req;
  logic [CSR_AW-1:0] csr_raddr;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_wen;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              busy;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output trap_req, trap_cause, trap_pc, mret_req, csr_rdata,
    input  csr_raddr, csr_wen, csr_waddr, csr_wdata, busy, redirect_valid, redirect_pc
  );

  modport slave (
    input  trap_req, trap_cause, trap_pc, mret_req, csr_rdata,
    output csr_raddr, csr_wen, csr_waddr, csr_wdata, busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_mstatus_upd.sv
// Combinational mstatus read-modify-write for trap entry (is_ret=0) and
// mret (is_ret=1). Only used when TRAP_SEQ_MSTATUS_EN is defined.
module trap_mstatus_upd
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old_val,
  input  logic            is_ret,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    if (is_ret) begin
      new_val[MSTATUS_MIE]  = old_val[MSTATUS_MPIE];
      new_val[MSTATUS_MPIE] = 1'b1;
    end else begin
      new_val[MSTATUS_MPIE] = old_val[MSTATUS_MIE];
      new_val[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / mret sequencer: owns the CSR write port while busy and issues a
// one-cycle PC redirect. Define TRAP_SEQ_MSTATUS_EN to add the mstatus update step.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic           clk,
  input  logic           rst,
  trap_sequencer_if.slave bus
);

  state_e            state, state_next;
  logic [XLEN-1:0]   pc_q, cause_q, redirect_pc_q;
  logic              is_trap_q;
  logic [CSR_AW-1:0] raddr, waddr;
  logic [XLEN-1:0]   wdata;
  logic              wen;

`ifdef TRAP_SEQ_MSTATUS_EN
  logic [XLEN-1:0] mstatus_new;

  trap_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
    .old_val (bus.csr_rdata),
    .is_ret  (state == W_STAT_R),
    .new_val (mstatus_new)
  );
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc_q          <= '0;
      cause_q       <= '0;
      is_trap_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.trap_req) begin
        pc_q      <= bus.trap_pc;
        cause_q   <= bus.trap_cause;
        is_trap_q <= 1'b1;
      end else if (state == IDLE && bus.mret_req) begin
        is_trap_q <= 1'b0;
      end
      if (state == RD_TGT) begin
        redirect_pc_q <= {bus.csr_rdata[XLEN-1:2], 2'b00};
      end
    end
  end

  // NOTE: every output of this block gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    raddr      = '0;
    wen        = 1'b0;
    waddr      = '0;
    wdata      = '0;
    case (state)
      IDLE: begin
        // trap wins over a simultaneous mret
        if (bus.trap_req) begin
          state_next = W_EPC;
        end else if (bus.mret_req) begin
`ifdef TRAP_SEQ_MSTATUS_EN
          state_next = W_STAT_R;
`else
          state_next = RD_TGT;
`endif
        end
      end
      W_EPC: begin
        wen        = 1'b1;
        waddr      = CSR_AW'(CSR_MEPC);
        wdata      = pc_q;
        state_next = W_CAUSE;
      end
      W_CAUSE: begin
        wen        = 1'b1;
        waddr      = CSR_AW'(CSR_MCAUSE);
        wdata      = cause_q;
`ifdef TRAP_SEQ_MSTATUS_EN
        state_next = W_STAT_T;
`else
        state_next = RD_TGT;
`endif
      end
`ifdef TRAP_SEQ_MSTATUS_EN
      W_STAT_T, W_STAT_R: begin
        raddr      = CSR_AW'(CSR_MSTATUS);
        wen        = 1'b1;
        waddr      = CSR_AW'(CSR_MSTATUS);
        wdata      = mstatus_new;
        state_next = RD_TGT;
      end
`endif
      RD_TGT: begin
        raddr      = is_trap_q ? CSR_AW'(CSR_MTVEC) : CSR_AW'(CSR_MEPC);
        state_next = REDIRECT;
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign bus.csr_raddr      = raddr;
  assign bus.csr_wen        = wen;
  assign bus.csr_waddr      = waddr;
  assign bus.csr_wdata      = wdata;
  assign bus.busy           = (state != IDLE);
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a small CSR file model, a table of
// trap/mret vectors and hand-written reset / back-to-back sequences.
module tb_trap_sequencer;
  import trap_pkg::*;

  localparam int XLEN   = 32;
  localparam int CSR_AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) bus ();

  trap_sequencer #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // CSR file model: combinational read, write on the clock edge
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic        tb_wen;
  logic [11:0] tb_waddr;
  logic [31:0] tb_wdata;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    wr_en   = tb_wen | bus.csr_wen;
    wr_addr = tb_wen ? tb_waddr : bus.csr_waddr;
    wr_data = tb_wen ? tb_wdata : bus.csr_wdata;
  end

  always @(posedge clk) begin
    if (wr_en) begin
      case (wr_addr)
        CSR_MSTATUS: m_mstatus <= wr_data;
        CSR_MTVEC:   m_mtvec   <= wr_data;
        CSR_MEPC:    m_mepc    <= wr_data;
        CSR_MCAUSE:  m_mcause  <= wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_raddr)
      CSR_MSTATUS: bus.csr_rdata = m_mstatus;
      CSR_MTVEC:   bus.csr_rdata = m_mtvec;
      CSR_MEPC:    bus.csr_rdata = m_mepc;
      CSR_MCAUSE:  bus.csr_rdata = m_mcause;
      default: ;
    endcase
  end

  typedef struct {
    bit          redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  typedef struct {
    bit          trap;
    bit          mret;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
    logic [31:0] exp_redir;
    logic [31:0] exp_mstat;
  } vec_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of bench time; observes the DUT on the falling edge.
  task automatic step();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (bus.csr_wen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_csr_wen: addr 0x%03h data 0x%08h (cycle %0d)",
                   bus.csr_waddr, bus.csr_wdata, cyc);
        end else begin
          e = sb.pop_front();
          check("wr_kind", 32'(e.redir), 32'd0);
          check("wr_addr", 32'(bus.csr_waddr), 32'(e.addr));
          check("wr_data", bus.csr_wdata, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (bus.redirect_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect: pc 0x%08h (cycle %0d)", bus.redirect_pc, cyc);
        end else begin
          e = sb.pop_front();
          check("redir_kind", 32'(e.redir), 32'd1);
          check("redir_pc", bus.redirect_pc, e.data);
          check("redir_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  function automatic void push_wr(input logic [11:0] a, input logic [31:0] d, input int c);
    sb.push_back('{redir: 1'b0, addr: a, data: d, cyc: c});
  endfunction

  function automatic void push_redir(input logic [31:0] pc, input int c);
    sb.push_back('{redir: 1'b1, addr: 12'h000, data: pc, cyc: c});
  endfunction

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    tb_wen   = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    step();
    tb_wen   = 1'b0;
  endtask

  // Drives a one-cycle request and queues the CSR writes / redirect it should cause.
  task automatic issue(input bit trap, input bit mret, input logic [31:0] pc,
                       input logic [31:0] cause, input logic [31:0] exp_redir,
                       input logic [31:0] exp_mstat);
    int t0;
    t0 = cyc;
    check("busy_t0", 32'(bus.busy), 32'd0);
    bus.trap_req   = trap;
    bus.mret_req   = mret;
    bus.trap_pc    = pc;
    bus.trap_cause = cause;
    if (trap) begin
      push_wr(CSR_MEPC, pc, t0 + 1);
      push_wr(CSR_MCAUSE, cause, t0 + 2);
`ifdef TRAP_SEQ_MSTATUS_EN
      push_wr(CSR_MSTATUS, exp_mstat, t0 + 3);
      push_redir(exp_redir, t0 + 5);
`else
      push_redir(exp_redir, t0 + 4);
`endif
    end else if (mret) begin
`ifdef TRAP_SEQ_MSTATUS_EN
      push_wr(CSR_MSTATUS, exp_mstat, t0 + 1);
      push_redir(exp_redir, t0 + 3);
`else
      push_redir(exp_redir, t0 + 2);
`endif
    end
    step();
    bus.trap_req   = 1'b0;
    bus.mret_req   = 1'b0;
    bus.trap_pc    = '0;
    bus.trap_cause = '0;
    check("busy_t1", 32'(bus.busy), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 40) begin
      step();
      n++;
    end
    check("drain_queue_empty", sb.size(), 32'd0);
    check("idle_after_seq", 32'(bus.busy), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    int t0;

    vecs[0] = '{1'b1, 1'b0, 32'h8000_0010, 32'(ECALL_M), 32'h8000_0101, 32'h0000_0000,
                32'h0000_0008, 32'h8000_0100, 32'h0000_1880};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0014,
                32'h0000_1880, 32'h8000_0014, 32'h0000_1888};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_1234, 32'(ECALL_M), 32'h0000_0403, 32'h5555_5555,
                32'h0000_0000, 32'h0000_0400, 32'h0000_1800};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_1880};
    vecs[4] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h8000_000B, 32'hFFFF_FFFE, 32'h0000_0000,
                32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFF7};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002,
                32'h0000_0080, 32'h0000_0000, 32'h0000_1888};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000,
                32'h0000_1808, 32'h0000_0000, 32'h0000_1880};

    rst            = 1'b1;
    tb_wen         = 1'b0;
    tb_waddr       = '0;
    tb_wdata       = '0;
    bus.trap_req   = 1'b0;
    bus.mret_req   = 1'b0;
    bus.trap_pc    = '0;
    bus.trap_cause = '0;

    step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_csr_wen", 32'(bus.csr_wen), 32'd0);
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_csr_raddr", 32'(bus.csr_raddr), 32'd0);
    poke(CSR_MSTATUS, 32'h0);
    poke(CSR_MTVEC, 32'h0);
    poke(CSR_MEPC, 32'h0);
    poke(CSR_MCAUSE, 32'h0);
    rst = 1'b0;
    step();

    // Table-driven trap / mret vectors
    for (int i = 0; i < 7; i++) begin
      poke(CSR_MTVEC, vecs[i].mtvec);
      poke(CSR_MEPC, vecs[i].mepc);
      poke(CSR_MSTATUS, vecs[i].mstatus);
      issue(vecs[i].trap, vecs[i].mret, vecs[i].pc, vecs[i].cause,
            vecs[i].exp_redir, vecs[i].exp_mstat);
      drain();
      repeat (2) step();
      check("redirect_pc_hold", bus.redirect_pc, vecs[i].exp_redir);
    end

    // Back-to-back: trap with an ignored pulse while busy, then mret right after REDIRECT
    poke(CSR_MTVEC, 32'h8000_0101);
    poke(CSR_MSTATUS, 32'h0000_0008);
    issue(1'b1, 1'b0, 32'h8000_0010, 32'(ECALL_M), 32'h8000_0100, 32'h0000_1880);
    bus.trap_req   = 1'b1;
    bus.trap_pc    = 32'h1357_9BDF;
    bus.trap_cause = 32'h0000_0007;
    step();
    bus.trap_req   = 1'b0;
    bus.trap_pc    = '0;
    bus.trap_cause = '0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("b2b_first_done", sb.size(), 32'd0);
    step();
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0010, 32'h0000_1888);
    drain();
    check("b2b_redirect_pc", bus.redirect_pc, 32'h8000_0010);

    // Reset asserted while W_CAUSE is on the write port
    poke(CSR_MTVEC, 32'h0000_4000);
    t0 = cyc;
    bus.trap_req   = 1'b1;
    bus.trap_pc    = 32'h1111_0000;
    bus.trap_cause = 32'(ECALL_M);
    push_wr(CSR_MEPC, 32'h1111_0000, t0 + 1);
    push_wr(CSR_MCAUSE, 32'(ECALL_M), t0 + 2);
    step();
    bus.trap_req   = 1'b0;
    bus.trap_pc    = '0;
    bus.trap_cause = '0;
    step();
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_csr_wen", 32'(bus.csr_wen), 32'd0);
    check("abort_csr_waddr", 32'(bus.csr_waddr), 32'd0);
    check("abort_csr_wdata", bus.csr_wdata, 32'd0);
    check("abort_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("abort_redirect_pc", bus.redirect_pc, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (8) step();
    check("abort_queue_empty", sb.size(), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);
    check("abort_redirect_pc_after", bus.redirect_pc, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle controller that sequences the machine-mode CSR file and PC redirect for `ecall` trap entry and `mret` return. It sits between the decode/execute stage and the CSR block. It owns the CSR single write port during trap sequences, stalls the core via `busy`, and emits a one-cycle redirect to the PC register.

## Interface
Parameters:
- `XLEN`, 32, data and PC width
- `CSR_AW`, 12, CSR address width

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `trap_req`  in  1  single-cycle pulse requesting trap entry; sampled only in IDLE
- `trap_cause`  in  XLEN  cause code (ecall from M-mode = 11); valid with `trap_req`
- `trap_pc`  in  XLEN  PC of the trapping instruction; valid with `trap_req`
- `mret_req`  in  1  single-cycle pulse requesting trap return; sampled only in IDLE
- `csr_raddr`  out  CSR_AW  CSR read address
- `csr_rdata`  in  XLEN  CSR read data; combinational from `csr_raddr`, same cycle
- `csr_wen`  out  1  CSR write enable
- `csr_waddr`  out  CSR_AW  CSR write address
- `csr_wdata`  out  XLEN  CSR write data
- `busy`  out  1  core stall; high whenever state ≠ IDLE
- `redirect_valid`  out  1  one-cycle pulse; PC must load `redirect_pc`
- `redirect_pc`  out  XLEN  redirect target (registered)

## Operation
FSM states:
- IDLE
- W_EPC, W_CAUSE, W_STAT_T (trap entry)
- W_STAT_R (return)
- RD_TGT
- REDIRECT

Trap entry:
- In IDLE, `trap_req`=1 latches `trap_pc` and `trap_cause` and moves to W_EPC.
- W_EPC: `csr_wen`=1, `csr_waddr`=0x341, `csr_wdata`=latched pc.
- W_CAUSE: `csr_wen`=1, `csr_waddr`=0x342, `csr_wdata`=latched cause.
- W_STAT_T (macro only; see Configuration), then RD_TGT.
- RD_TGT: `csr_raddr`=0x305; latch `redirect_pc` = `csr_rdata` & ~3 (direct mode only).

Return:
- In IDLE, `mret_req`=1 moves to W_STAT_R (macro only), then RD_TGT.
- RD_TGT: `csr_raddr`=0x341; latch `redirect_pc` = `csr_rdata` & ~3.

Common:
- REDIRECT: `redirect_valid`=1, then IDLE.
- Simultaneous `trap_req` and `mret_req` in IDLE: trap wins; the mret is dropped.
- Requests outside IDLE are ignored. The core guarantees none occur while `busy` is high.
- `csr_wen` is 0 in every state not listed above. `csr_raddr`, `csr_waddr` and `csr_wdata` are 0 when unused.

## Timing
- T0 is the acceptance cycle. `busy` rises at T1 (registered state).
- Trap without macro: writes at T1/T2, RD_TGT at T3, `redirect_valid` at T4, IDLE at T5.
- With macro, each sequence takes one extra cycle.
- mret without macro: RD_TGT at T1, `redirect_valid` at T2.
- `redirect_pc` holds its value until the next RD_TGT.
- Reset values:
  - state = IDLE
  - `busy`, `redirect_valid`, `csr_wen` = 0
  - `redirect_pc` and latched pc/cause = 0
- Reset mid-sequence aborts immediately: no further CSR writes and no redirect. Writes already committed remain in the CSR file.
- Back-to-back: a new request is accepted in the first IDLE cycle after REDIRECT.

## Configuration
Macro `TRAP_SEQ_MSTATUS_EN`.

Defined:
- W_STAT_T: `csr_raddr`=0x300; writes 0x300 with MPIE(bit7)←MIE(bit3), MIE←0, MPP(bits 12:11)←2'b11; other bits from `csr_rdata`.
- W_STAT_R: same read-modify-write with MIE←MPIE, MPIE←1.

Undefined:
- W_STAT_T and W_STAT_R do not exist, and mstatus is never written.

## Structure
- Package `trap_pkg`: state enum; CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342); mstatus bit indices MIE/MPIE/MPP; cause constant ECALL_M=11.
- One combinational sub-module, `trap_mstatus_upd` (inputs old value and entry/return flag; output new value). It is instantiated only when `TRAP_SEQ_MSTATUS_EN` is defined.

## Test plan
- Reset with `rst` high mid-W_CAUSE → outputs zero at once; after release no `csr_wen` and no `redirect_valid`.
- `trap_req`, pc=0x80000010, cause=11, mtvec=0x80000101 → 0x341←0x80000010 at T1, 0x342←11 at T2, `redirect_valid` with `redirect_pc`=0x80000100 at T4 (T5 with macro).
- `mret_req` with mepc=0x80000014 → `redirect_pc`=0x80000014, `redirect_valid` at T2 (T3 with macro); no writes without macro.
- `trap_req` and `mret_req` same cycle → trap sequence only; exactly one `redirect_valid`.
- Macro on, mstatus=0x00000008: trap → 0x300←0x00001880; then mret → 0x300←0x00001888.
- `trap_req` pulsed while `busy` → ignored; exactly one redirect; new request accepted the cycle after REDIRECT.
